// File: rtl/flag_cond_seq.sv
// Microprogram sequencer that drives the microinstruction ROM address.
// It decodes the op/cond/target fields that the ROM returns, and it branches
// on the 2-bit result flags captured from the operational block.
module flag_cond_seq #(
    parameter int AW       = 6,
    parameter int WAIT_MAX = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [1:0]    flags,
    input  logic          flags_vld,
    input  logic [1:0]    mi_op,
    input  logic [1:0]    mi_cond,
    input  logic [AW-1:0] mi_addr,
    output logic [AW-1:0] uaddr,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic          taken
);

    localparam int WCW = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
    localparam logic [WCW-1:0] WCNT_LAST = WCW'(WAIT_MAX - 1);

    localparam logic [1:0] OP_NEXT   = 2'b00;
    localparam logic [1:0] OP_JUMP   = 2'b01;
    localparam logic [1:0] OP_BRANCH = 2'b10;
    localparam logic [1:0] OP_HALT   = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RUN   = 2'b01,
        S_WAITF = 2'b10,
        S_HALT  = 2'b11
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   uaddr_q, uaddr_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic            taken_q, taken_d;
    logic [1:0]      flags_q, flags_d;
    logic            fresh_q, fresh_d;
    logic [WCW-1:0]  wcnt_q, wcnt_d;

    // Flags seen by a branch: a strobe in the same cycle bypasses the register.
    logic [1:0]      ef;
    logic            avail;
    logic            br_hit;
    logic [AW-1:0]   uaddr_inc;

    // Branch evaluation terms shared by RUN and WAITF.
    always_comb begin
        ef        = flags_vld ? flags : flags_q;
        avail     = flags_vld | fresh_q;
        br_hit    = (ef == mi_cond);
        uaddr_inc = uaddr_q + AW'(1);
    end

    // Next-state logic for the sequencer and the flag capture register.
    always_comb begin
        state_d = state_q;
        uaddr_d = uaddr_q;
        done_d  = done_q;
        err_d   = err_q;
        taken_d = 1'b0;
        wcnt_d  = wcnt_q;
        flags_d = flags_vld ? flags : flags_q;
        fresh_d = flags_vld ? 1'b1 : fresh_q;

        case (state_q)
            S_IDLE, S_HALT: begin
                if (start) begin
                    uaddr_d = '0;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                    state_d = S_RUN;
                end
            end

            S_RUN: begin
                case (mi_op)
                    OP_NEXT: uaddr_d = uaddr_inc;
                    OP_JUMP: uaddr_d = mi_addr;
                    OP_BRANCH: begin
                        if (avail) begin
                            // Evaluation consumes the flags, including a bypassed strobe.
                            fresh_d = 1'b0;
                            taken_d = br_hit;
                            uaddr_d = br_hit ? mi_addr : uaddr_inc;
                        end else begin
                            wcnt_d  = '0;
                            state_d = S_WAITF;
                        end
                    end
                    OP_HALT: begin
                        done_d  = 1'b1;
                        state_d = S_HALT;
                    end
                    default: uaddr_d = uaddr_q;
                endcase
            end

            S_WAITF: begin
                // Address is held, so the ROM keeps presenting the same BRANCH.
                if (avail) begin
                    fresh_d = 1'b0;
                    taken_d = br_hit;
                    uaddr_d = br_hit ? mi_addr : uaddr_inc;
                    state_d = S_RUN;
                end else if (wcnt_q == WCNT_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_HALT;
                end else begin
                    wcnt_d  = wcnt_q + WCW'(1);
                end
            end

            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d == S_RUN) || (state_d == S_WAITF);
    end

    // State and output registers; reset takes effect without a clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            uaddr_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            taken_q <= 1'b0;
            flags_q <= 2'b00;
            fresh_q <= 1'b0;
            wcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            uaddr_q <= uaddr_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            taken_q <= taken_d;
            flags_q <= flags_d;
            fresh_q <= fresh_d;
            wcnt_q  <= wcnt_d;
        end
    end

    assign uaddr = uaddr_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign err   = err_q;
    assign taken = taken_q;

endmodule

// File: tb/tb_flag_cond_seq.sv
// Bench for flag_cond_seq: directed microprogram steps with a scoreboard of
// expected {uaddr, busy, done, err, taken} per clock.
module tb_flag_cond_seq;

    localparam int AW       = 6;
    localparam int WAIT_MAX = 8;

    localparam logic [1:0] NX = 2'b00;
    localparam logic [1:0] JP = 2'b01;
    localparam logic [1:0] BR = 2'b10;
    localparam logic [1:0] HL = 2'b11;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [1:0]    flags;
    logic          flags_vld;
    logic [1:0]    mi_op;
    logic [1:0]    mi_cond;
    logic [AW-1:0] mi_addr;
    logic [AW-1:0] uaddr;
    logic          busy;
    logic          done;
    logic          err;
    logic          taken;

    int n_vec = 0;
    int n_bad = 0;

    logic [9:0] exp_q[$];
    string      tag_q[$];

    flag_cond_seq #(.AW(AW), .WAIT_MAX(WAIT_MAX)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .flags     (flags),
        .flags_vld (flags_vld),
        .mi_op     (mi_op),
        .mi_cond   (mi_cond),
        .mi_addr   (mi_addr),
        .uaddr     (uaddr),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .taken     (taken)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [9:0] pk(input int u, input logic b, input logic d,
                                      input logic e, input logic t);
        logic [5:0] ua;
        ua = u[5:0];
        return {ua, b, d, e, t};
    endfunction

    task automatic check_vec(input string tag, input logic [9:0] got, input logic [9:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got uaddr=%0d busy=%b done=%b err=%b taken=%b, expected uaddr=%0d busy=%b done=%b err=%b taken=%b",
                     tag, got[9:4], got[3], got[2], got[1], got[0],
                     exp[9:4], exp[3], exp[2], exp[1], exp[0]);
        end
    endtask

    // Drive one clock of stimulus, queue its expectation, compare after the edge.
    task automatic apply(input string tag, input logic st, input logic fv,
                         input logic [1:0] fl, input logic [1:0] op,
                         input logic [1:0] cond, input int ad, input logic [9:0] exp);
        logic [9:0] e;
        string      t;
        start     = st;
        flags_vld = fv;
        flags     = fl;
        mi_op     = op;
        mi_cond   = cond;
        mi_addr   = ad[AW-1:0];
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        check_vec(t, {uaddr, busy, done, err, taken}, e);
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        flags     = 2'b00;
        flags_vld = 1'b0;
        mi_op     = NX;
        mi_cond   = 2'b00;
        mi_addr   = '0;
        repeat (2) @(posedge clk);
        #1;
        check_vec("reset", {uaddr, busy, done, err, taken}, pk(0, 0, 0, 0, 0));
        rst_n = 1'b1;

        // Sequential stepping, jump to top of the address space and wrap
        apply("start",        1, 0, 0, NX, 0, 0,  pk(0, 1, 0, 0, 0));
        apply("next1",        0, 0, 0, NX, 0, 0,  pk(1, 1, 0, 0, 0));
        apply("next2_st_ign", 1, 0, 0, NX, 0, 0,  pk(2, 1, 0, 0, 0));
        apply("next3",        0, 0, 0, NX, 0, 0,  pk(3, 1, 0, 0, 0));
        apply("jump63",       0, 0, 0, JP, 0, 63, pk(63, 1, 0, 0, 0));
        apply("wrap",         0, 0, 0, NX, 0, 0,  pk(0, 1, 0, 0, 0));
        for (int i = 1; i <= 4; i++)
            apply("next_to4", 0, 0, 0, NX, 0, 0, pk(i, 1, 0, 0, 0));
        apply("halt",         0, 0, 0, HL, 0, 0,  pk(4, 0, 1, 0, 0));
        apply("halt_hold",    0, 0, 0, NX, 0, 0,  pk(4, 0, 1, 0, 0));

        // Asynchronous reset in the middle of a run
        apply("restart",      1, 0, 0, NX, 0, 0,  pk(0, 1, 0, 0, 0));
        for (int i = 1; i <= 5; i++)
            apply("next_to5", 0, 0, 0, NX, 0, 0, pk(i, 1, 0, 0, 0));
        rst_n = 1'b0;
        #2;
        check_vec("rst_async", {uaddr, busy, done, err, taken}, pk(0, 0, 0, 0, 0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Branch on fresh flags, then a branch that must wait
        apply("start2",       1, 0, 0,     NX, 0,     0,  pk(0, 1, 0, 0, 0));
        apply("strobe10",     0, 1, 2'b10, NX, 0,     0,  pk(1, 1, 0, 0, 0));
        apply("br_fresh",     0, 0, 0,     BR, 2'b10, 20, pk(20, 1, 0, 0, 1));
        apply("br_wait",      0, 0, 0,     BR, 2'b11, 9,  pk(20, 1, 0, 0, 0));
        apply("waitf_hold1",  0, 0, 0,     BR, 2'b11, 9,  pk(20, 1, 0, 0, 0));
        apply("waitf_hold2",  0, 0, 0,     BR, 2'b11, 9,  pk(20, 1, 0, 0, 0));
        apply("wait_resolve", 0, 1, 2'b11, BR, 2'b11, 9,  pk(9, 1, 0, 0, 1));
        apply("taken_pulse",  0, 0, 0,     NX, 0,     0,  pk(10, 1, 0, 0, 0));

        // Not-taken branch on bypassed flags; the strobe must be consumed
        apply("jump7",        0, 0, 0,     JP, 0,     7,  pk(7, 1, 0, 0, 0));
        apply("br_bypass_nt", 0, 1, 2'b01, BR, 2'b00, 40, pk(8, 1, 0, 0, 0));
        apply("br_consumed",  0, 0, 0,     BR, 2'b01, 50, pk(8, 1, 0, 0, 0));

        // Timeout after WAIT_MAX cycles without a strobe; start ignored while busy
        for (int i = 0; i < WAIT_MAX - 1; i++)
            apply("timeout_wait", (i == 3), 0, 0, BR, 2'b01, 50, pk(8, 1, 0, 0, 0));
        apply("timeout",      0, 0, 0, BR, 2'b01, 50, pk(8, 0, 0, 1, 0));
        apply("err_hold",     0, 0, 0, NX, 0,     0,  pk(8, 0, 0, 1, 0));
        apply("restart_err",  1, 0, 0, NX, 0,     0,  pk(0, 1, 0, 0, 0));

        // Strobe on the last permitted wait cycle still resolves the branch
        apply("br_wait2",     0, 0, 0, BR, 2'b00, 33, pk(0, 1, 0, 0, 0));
        for (int i = 0; i < WAIT_MAX - 1; i++)
            apply("late_wait", 0, 0, 0, BR, 2'b00, 33, pk(0, 1, 0, 0, 0));
        apply("late_strobe",  0, 1, 2'b00, BR, 2'b00, 33, pk(33, 1, 0, 0, 1));
        apply("halt2",        0, 0, 0,     HL, 0,     0,  pk(33, 0, 1, 0, 0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
